// File: rtl/spmv_stream_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spmv_stream_fetch: tagged 64-bit load streamer with an 8-entry reorder buffer
// rev 1.0
// ---------------------------------------------------------------------------
module spmv_stream_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] base_addr,
  input  logic [31:0] count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        req_mem_ld,
  output logic        req_mem_st,
  output logic [47:0] req_mem_addr,
  output logic [63:0] req_mem_d_or_tag,
  input  logic        req_mem_stall,
  input  logic        rsp_mem_push,
  input  logic [2:0]  rsp_mem_tag,
  input  logic [63:0] rsp_mem_q,
  output logic        rsp_mem_stall,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready
);

  localparam int DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [47:0] base_q, base_d;
  logic [31:0] count_q, count_d;
  logic [31:0] issued_q, issued_d;
  logic [31:0] popped_q, popped_d;
  logic [2:0]  head_q, head_d;
  logic [2:0]  tail_q, tail_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  outst_q, outst_d;
  logic [63:0] buf_q [DEPTH];
  logic [63:0] buf_d [DEPTH];
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic [31:0] occupancy;
  logic        issue_fire;
  logic        pop_fire;
  logic        rsp_ok;

  always_comb begin
    occupancy  = issued_q - popped_q;
    req_mem_ld = (state_q == RUN) && (issued_q < count_q) && (occupancy < 32'd8);
    issue_fire = req_mem_ld && !req_mem_stall;
    out_valid  = valid_q[head_q];
    out_data   = buf_q[head_q];
    pop_fire   = out_valid && out_ready;
    // A slot accepts data only between its issue and its pop, and only once.
    rsp_ok     = rsp_mem_push && outst_q[rsp_mem_tag] && !valid_q[rsp_mem_tag];
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    issued_d = issued_q;
    popped_d = popped_q;
    head_d   = head_q;
    tail_d   = tail_q;
    valid_d  = valid_q;
    outst_d  = outst_q;
    buf_d    = buf_q;
    err_d    = err_q;
    done_d   = 1'b0;

    if (rsp_ok) begin
      valid_d[rsp_mem_tag] = 1'b1;
      buf_d[rsp_mem_tag]   = rsp_mem_q;
    end

    if (pop_fire) begin
      valid_d[head_q] = 1'b0;
      outst_d[head_q] = 1'b0;
      head_d          = head_q + 3'd1;
      popped_d        = popped_q + 32'd1;
    end

    if (issue_fire) begin
      outst_d[tail_q] = 1'b1;
      tail_d          = tail_q + 3'd1;
      issued_d        = issued_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d    = 1'b0;
          base_d   = base_addr;
          count_d  = count;
          issued_d = 32'd0;
          popped_d = 32'd0;
          head_d   = 3'd0;
          tail_d   = 3'd0;
          if (count != 32'd0) state_d = RUN;
          else                done_d  = 1'b1;
        end
      end
      RUN: begin
        if (issue_fire && (issued_d == count_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop_fire && (popped_d == count_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Evaluated after the start clear so a stray response in that cycle still flags.
    if (rsp_mem_push && !rsp_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= 48'd0;
      count_q  <= 32'd0;
      issued_q <= 32'd0;
      popped_q <= 32'd0;
      head_q   <= 3'd0;
      tail_q   <= 3'd0;
      valid_q  <= 8'd0;
      outst_q  <= 8'd0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= 64'd0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      valid_q  <= valid_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
      done_q   <= done_d;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign err              = err_q;
  assign req_mem_st       = 1'b0;
  assign rsp_mem_stall    = 1'b0;
  assign req_mem_addr     = base_q + {13'd0, issued_q, 3'd0};
  assign req_mem_d_or_tag = {61'd0, tail_q};

endmodule
`default_nettype wire

// File: tb/tb_spmv_stream_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spmv_stream_fetch: directed self-checking bench for spmv_stream_fetch
// rev 1.0
// ---------------------------------------------------------------------------
module tb_spmv_stream_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [47:0] base_addr;
  logic [31:0] count;
  logic        busy, done, err;
  logic        req_mem_ld, req_mem_st;
  logic [47:0] req_mem_addr;
  logic [63:0] req_mem_d_or_tag;
  logic        req_mem_stall;
  logic        rsp_mem_push;
  logic [2:0]  rsp_mem_tag;
  logic [63:0] rsp_mem_q;
  logic        rsp_mem_stall;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;

  spmv_stream_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .base_addr        (base_addr),
    .count            (count),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .req_mem_ld       (req_mem_ld),
    .req_mem_st       (req_mem_st),
    .req_mem_addr     (req_mem_addr),
    .req_mem_d_or_tag (req_mem_d_or_tag),
    .req_mem_stall    (req_mem_stall),
    .rsp_mem_push     (rsp_mem_push),
    .rsp_mem_tag      (rsp_mem_tag),
    .rsp_mem_q        (rsp_mem_q),
    .rsp_mem_stall    (rsp_mem_stall),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] addr;
    logic [2:0]  tag;
    logic [63:0] data;
  } vec_t;

  vec_t        vecs [4];
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  logic        auto_rsp = 1'b0;
  logic [47:0] req_addr_q [$];
  logic [2:0]  req_tag_q  [$];
  logic [47:0] pend_addr  [$];
  logic [2:0]  pend_tag   [$];
  logic [63:0] outs       [$];

  function automatic logic [63:0] memword(input logic [47:0] a);
    return {32'hC0DE_0000, a[34:3]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Observe mid-cycle, advance one edge, then play the auto-responder.
  task automatic tick();
    #2;
    if (req_mem_ld && !req_mem_stall) begin
      req_addr_q.push_back(req_mem_addr);
      req_tag_q.push_back(req_mem_d_or_tag[2:0]);
      pend_addr.push_back(req_mem_addr);
      pend_tag.push_back(req_mem_d_or_tag[2:0]);
    end
    if (out_valid && out_ready) outs.push_back(out_data);
    if (done) done_seen++;
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      if (pend_tag.size() > 0) begin
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = pend_tag.pop_front();
        rsp_mem_q    = memword(pend_addr.pop_front());
      end else begin
        rsp_mem_push = 1'b0;
      end
    end
  endtask

  task automatic clear_logs();
    req_addr_q.delete();
    req_tag_q.delete();
    pend_addr.delete();
    pend_tag.delete();
    outs.delete();
  endtask

  task automatic start_fetch(input logic [47:0] b, input logic [31:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int bound);
    int d0;
    int n;
    d0 = done_seen;
    n  = 0;
    while (done_seen == d0 && n < bound) begin
      tick();
      n++;
    end
    check({name, "_done_timeout"}, (done_seen == d0) ? 64'd1 : 64'd0, 64'd0);
  endtask

  task automatic wait_reqs(input string name, input int n, input int bound);
    int k;
    k = 0;
    while (req_addr_q.size() < n && k < bound) begin
      tick();
      k++;
    end
    check({name, "_req_timeout"}, (req_addr_q.size() < n) ? 64'd1 : 64'd0, 64'd0);
  endtask

  function automatic logic [63:0] out_at(input int i);
    return (i < outs.size()) ? outs[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [47:0] addr_at(input int i);
    return (i < req_addr_q.size()) ? req_addr_q[i] : 48'hFFFF_FFFF_FFFF;
  endfunction

  function automatic logic [2:0] tag_at(input int i);
    return (i < req_tag_q.size()) ? req_tag_q[i] : 3'bxxx;
  endfunction

  initial begin
    int d0;

    vecs[0] = '{48'h1000, 3'd0, 64'hC0DE0000_00000200};
    vecs[1] = '{48'h1008, 3'd1, 64'hC0DE0000_00000201};
    vecs[2] = '{48'h1010, 3'd2, 64'hC0DE0000_00000202};
    vecs[3] = '{48'h1018, 3'd3, 64'hC0DE0000_00000203};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0;
    req_mem_stall = 1'b0; rsp_mem_push = 1'b0; rsp_mem_tag = '0; rsp_mem_q = '0;
    out_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ld", req_mem_ld, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_addr", req_mem_addr, 0);
    check("rst_tag", req_mem_d_or_tag, 0);
    check("rst_st", req_mem_st, 0);
    check("rst_rsp_stall", rsp_mem_stall, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic in-order fetch, 1-cycle memory
    clear_logs();
    auto_rsp = 1'b1;
    d0 = done_seen;
    start_fetch(48'h1000, 32'd4);
    check("t1_busy", busy, 1);
    run_until_done("t1", 40);
    repeat (3) tick();
    check("t1_done_pulses", done_seen - d0, 1);
    check("t1_nreq", req_addr_q.size(), 4);
    check("t1_nout", outs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), addr_at(i), vecs[i].addr);
      check($sformatf("t1_tag%0d", i), tag_at(i), vecs[i].tag);
      check($sformatf("t1_data%0d", i), out_at(i), vecs[i].data);
    end
    check("t1_busy_end", busy, 0);
    check("t1_err", err, 0);

    // Withheld responses: window of 8, then tag wrap
    clear_logs();
    auto_rsp = 1'b0;
    rsp_mem_push = 1'b0;
    start_fetch(48'h0, 32'd20);
    repeat (15) tick();
    check("t2_nreq_window", req_addr_q.size(), 8);
    check("t2_ld_blocked", req_mem_ld, 0);
    check("t2_busy", busy, 1);
    auto_rsp = 1'b1;
    run_until_done("t2", 300);
    check("t2_nreq", req_addr_q.size(), 20);
    check("t2_tag7", tag_at(7), 3'd7);
    check("t2_tag8_wrap", tag_at(8), 3'd0);
    check("t2_tag15", tag_at(15), 3'd7);
    check("t2_addr19", addr_at(19), 48'h98);
    check("t2_nout", outs.size(), 20);
    check("t2_data8", out_at(8), 64'hC0DE0000_00000008);
    check("t2_data19", out_at(19), 64'hC0DE0000_00000013);

    // Out-of-order responses 3,1,0,2
    clear_logs();
    auto_rsp = 1'b0;
    rsp_mem_push = 1'b0;
    start_fetch(48'h2000, 32'd4);
    wait_reqs("t3", 4, 20);
    rsp_mem_push = 1'b1; rsp_mem_tag = 3'd3; rsp_mem_q = 64'hC0DE0000_00000403;
    tick();
    check("t3_valid_after3", out_valid, 0);
    rsp_mem_tag = 3'd1; rsp_mem_q = 64'hC0DE0000_00000401;
    tick();
    check("t3_valid_after1", out_valid, 0);
    rsp_mem_tag = 3'd0; rsp_mem_q = 64'hC0DE0000_00000400;
    tick();
    check("t3_valid_after0", out_valid, 1);
    rsp_mem_tag = 3'd2; rsp_mem_q = 64'hC0DE0000_00000402;
    tick();
    rsp_mem_push = 1'b0;
    run_until_done("t3", 20);
    check("t3_nout", outs.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_data%0d", i), out_at(i), 64'hC0DE0000_00000400 + 64'(i));
    check("t3_err", err, 0);

    // Stall for 5 cycles mid-run
    clear_logs();
    auto_rsp = 1'b1;
    start_fetch(48'h3000, 32'd6);
    wait_reqs("t4", 2, 20);
    req_mem_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_hold_addr%0d", k), req_mem_addr, 48'h3010);
      check($sformatf("t4_hold_tag%0d", k), req_mem_d_or_tag, 64'd2);
      check($sformatf("t4_hold_ld%0d", k), req_mem_ld, 1);
      tick();
    end
    req_mem_stall = 1'b0;
    run_until_done("t4", 60);
    check("t4_nreq", req_addr_q.size(), 6);
    check("t4_nout", outs.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t4_addr%0d", i), addr_at(i), 48'h3000 + 48'(8 * i));
      check($sformatf("t4_data%0d", i), out_at(i), 64'hC0DE0000_00000600 + 64'(i));
    end

    // Spurious response while idle, then zero-length start
    clear_logs();
    auto_rsp = 1'b0;
    rsp_mem_push = 1'b1; rsp_mem_tag = 3'd5; rsp_mem_q = 64'h1234;
    tick();
    rsp_mem_push = 1'b0;
    check("t5_err_set", err, 1);
    check("t5_no_valid", out_valid, 0);
    start_fetch(48'h7000, 32'd0);
    check("t5_done", done, 1);
    check("t5_err_clr", err, 0);
    check("t5_busy", busy, 0);
    tick();
    check("t5_done_once", done, 0);
    check("t5_nreq", req_addr_q.size(), 0);

    // Reset mid-fetch, late response, then a clean fetch
    clear_logs();
    auto_rsp = 1'b0;
    start_fetch(48'h4000, 32'd6);
    wait_reqs("t6", 3, 20);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ld", req_mem_ld, 0);
    check("t6_rst_addr", req_mem_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_mem_push = 1'b1; rsp_mem_tag = 3'd1; rsp_mem_q = 64'h5555;
    tick();
    rsp_mem_push = 1'b0;
    check("t6_late_err", err, 1);
    check("t6_late_no_valid", out_valid, 0);
    clear_logs();
    auto_rsp = 1'b1;
    start_fetch(48'h5000, 32'd3);
    check("t6_err_clr", err, 0);
    run_until_done("t6", 40);
    check("t6_nreq", req_addr_q.size(), 3);
    check("t6_nout", outs.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t6_data%0d", i), out_at(i), 64'hC0DE0000_00000A00 + 64'(i));
    check("t6_err_end", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spmv_stream_fetch.md
SPMV_STREAM_FETCH -- requirements
Module: spmv_stream_fetch

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: start  input  1  one-cycle request to begin a fetch; sampled only in IDLE.
REQ-004 SHALL have port: base_addr  input  48  byte address of the first 64-bit word; captured on accepted start.
REQ-005 SHALL have port: count  input  32  number of 64-bit words to fetch; captured on accepted start.
REQ-006 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when a fetch completes.
REQ-008 SHALL have port: err  output  1  sticky flag, set on an unexpected response tag.
REQ-009 SHALL have port: req_mem_ld  output  1  load request valid.
REQ-010 SHALL have port: req_mem_st  output  1  constant 0.
REQ-011 SHALL have port: req_mem_addr  output  48  load byte address.
REQ-012 SHALL have port: req_mem_d_or_tag  output  64  tag in bits [2:0]; bits [63:3] are 0.
REQ-013 SHALL have port: req_mem_stall  input  1  memory cannot accept a request this cycle.
REQ-014 SHALL have port: rsp_mem_push, rsp_mem_tag, rsp_mem_q  inputs  1/3/64  response valid, tag, data.
REQ-015 SHALL have port: rsp_mem_stall  output  1  constant 0; every response is always accepted.
REQ-016 SHALL have port: out_valid, out_data  outputs  1/64  in-order data stream.
REQ-017 SHALL have port: out_ready  input  1  consumer accepts out_data.

Function
REQ-018 SHALL implement states IDLE, RUN and DRAIN.
REQ-019 IDLE, start=1, count!=0: SHALL go to RUN and capture base_addr and count; issued, popped, head and tail counters SHALL be zeroed.
REQ-020 IDLE, start=1, count=0: SHALL stay in IDLE and pulse done on the next cycle; no request is issued.
REQ-021 start while busy SHALL be ignored.
REQ-022 SHALL provide an 8-entry reorder buffer; an entry's slot index equals its tag.
REQ-023 Request i SHALL use tag i mod 8 and address base_addr + 8*i, with the address wrapping modulo 2^48.
REQ-024 req_mem_ld SHALL be combinational: high only when state=RUN, issued<count and occupancy<8.
REQ-025 A request SHALL be accepted on an edge where req_mem_ld=1 and req_mem_stall=0; issued increments on accept.
REQ-026 While stalled, req_mem_ld, address and tag SHALL hold steady.
REQ-027 Occupancy SHALL equal issued minus popped, range 0..8; issue and pop in the same cycle SHALL leave it unchanged.
REQ-028 On rsp_mem_push, if the tag slot is outstanding and not yet valid, the buffer SHALL store rsp_mem_q and set that slot's valid bit.
REQ-029 A response to a slot that is not outstanding, or already valid, SHALL be discarded and SHALL set err.
REQ-030 out_valid SHALL equal valid[head]; out_data SHALL equal buf[head].
REQ-031 Minimum latency from response push to out_valid SHALL be 1 cycle.
REQ-032 A pop occurs when out_valid=1 and out_ready=1; it SHALL clear valid[head], increment head mod 8 and increment popped.
REQ-033 Responses SHALL be accepted in any order; output order SHALL always equal request order.
REQ-034 RUN SHALL go to DRAIN on the edge where the final request is accepted.
REQ-035 DRAIN SHALL go to IDLE on the edge where popped reaches count; done SHALL be high for exactly the following cycle.
REQ-036 A response and a pop on the same slot in the same cycle cannot occur; the slot SHALL be refilled only after reissue.
REQ-037 err SHALL be cleared only by reset or by an accepted start.

Reset
REQ-038 rst_n=0 SHALL immediately force IDLE and clear all valid bits and counters.
REQ-039 While rst_n=0, busy, done, err, req_mem_ld and out_valid SHALL all be 0, and req_mem_addr and req_mem_d_or_tag SHALL be 0.
REQ-040 Reset mid-fetch SHALL abandon outstanding requests; responses arriving after reset release SHALL set err and be discarded.

Verification
REQ-041 Test: start, base=0x1000, count=4, no stall, in-order memory with 1-cycle latency -> addresses 0x1000/08/10/18, tags 0..3, out_data equals mem[0x200..0x203], done pulses once.
REQ-042 Test: count=20, memory withholds all responses -> exactly 8 requests issued, then req_mem_ld=0; once pops begin, tags wrap 7->0.
REQ-043 Test: responses for tags 3,1,0,2 in that order -> out_valid first rises the cycle after tag 0 arrives; output order is words 0,1,2,3.
REQ-044 Test: req_mem_stall=1 for 5 cycles during RUN -> the address is held steady, no request is lost or duplicated, and the total request count equals count.
REQ-045 Test: spurious push with tag 5 while idle -> err=1 and out_valid remains 0; start=1 with count=0 -> done pulses with no request issued and err is cleared.
REQ-046 Test: rst_n low for 1 cycle after 3 of 6 requests issued -> IDLE, busy=0; a late response sets err; a new fetch then completes correctly.
